sdram_arb: RTL and testbench

SDRAM_ARB -- requirements
Module: sdram_arb

---
 rtl/sdram_pkg.sv | 27 ++
 rtl/sdram_arb.sv | 148 ++++++++++++++
 tb/tb_sdram_arb.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_pkg
// Brief    : Shared types for the sdram_mac register-bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_pkg;

  localparam int C_ADDR_W = 8;
  localparam int C_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [C_ADDR_W-1:0] addr;
    logic [C_DATA_W-1:0] wd;
    logic                we;
    logic                we_len;
    logic                we_a;
  } reg_bus_t;

endpackage
`default_nettype wire

// File: rtl/sdram_arb.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb
// Brief    : Round-robin arbiter muxing two requesters onto the sdram_mac
//            register bus. Define SDRAM_ARB_TIMEOUT_EN for the grant watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arb
  import sdram_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [1:0]          REQ,
  output logic [1:0]          GNT,
  input  logic [C_ADDR_W-1:0] ADDR0,
  input  logic [C_ADDR_W-1:0] ADDR1,
  input  logic [C_DATA_W-1:0] WD0,
  input  logic [C_DATA_W-1:0] WD1,
  input  logic                WE0,
  input  logic                WE1,
  input  logic                WE_LEN0,
  input  logic                WE_LEN1,
  input  logic                WE_A0,
  input  logic                WE_A1,
  output logic [C_DATA_W-1:0] RD,
  output logic [1:0]          BUSY_OUT,
  output logic [C_ADDR_W-1:0] M_ADDR,
  output logic [C_DATA_W-1:0] M_WD,
  output logic                M_WE,
  output logic                M_WE_LEN,
  output logic                M_WE_A,
  input  logic [C_DATA_W-1:0] M_RD,
  input  logic                M_BUSY
);

  arb_state_t r_state;
  logic [1:0] r_gnt;
  logic       r_last;
  logic [1:0] w_block;
  logic [1:0] w_req_elig;
  logic [1:0] w_pick;
  logic       w_timeout;
  reg_bus_t   w_bus0;
  reg_bus_t   w_bus1;
  reg_bus_t   w_sel;

  // With both requesting, the one not served last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11)
      return last ? 2'b01 : 2'b10;
    else
      return req;
  endfunction

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("sdram_arb: TIMEOUT_CYCLES must be at least 2");
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int C_WDT_W = $clog2(TIMEOUT_CYCLES);

  logic [C_WDT_W-1:0] r_wdt;
  logic [1:0]         r_block;

  assign w_timeout = (r_wdt == C_WDT_W'(TIMEOUT_CYCLES - 1));
  assign w_block   = r_block;

  // A timed-out requester stays locked out until it drops REQ for a cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wdt   <= '0;
      r_block <= 2'b00;
    end else begin
      if (r_state == GRANT && !w_timeout)
        r_wdt <= r_wdt + C_WDT_W'(1);
      else
        r_wdt <= '0;
      r_block <= (r_block & REQ) |
                 ({2{r_state == GRANT && w_timeout}} & r_gnt & REQ);
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_block   = 2'b00;
`endif

  assign w_req_elig = REQ & ~w_block;
  assign w_pick     = rr_pick(w_req_elig, r_last);

  // While granted, r_last is the index of the current owner.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req_elig) begin
            r_state <= GRANT;
            r_gnt   <= w_pick;
            r_last  <= w_pick[1];
          end
        end
        GRANT: begin
          if (!REQ[r_last] || w_timeout) begin
            r_state <= DRAIN;
            r_gnt   <= 2'b00;
          end
        end
        DRAIN: begin
          if (!M_BUSY)
            r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 2'b00;
        end
      endcase
    end
  end

  assign w_bus0 = '{addr: ADDR0, wd: WD0, we: WE0, we_len: WE_LEN0, we_a: WE_A0};
  assign w_bus1 = '{addr: ADDR1, wd: WD1, we: WE1, we_len: WE_LEN1, we_a: WE_A1};

  always_comb begin
    w_sel = (r_state == GRANT && r_gnt[1]) ? w_bus1 : w_bus0;
    if (RESET || r_state != GRANT) begin
      w_sel.we     = 1'b0;
      w_sel.we_len = 1'b0;
      w_sel.we_a   = 1'b0;
    end
  end

  assign GNT         = r_gnt;
  assign M_ADDR      = w_sel.addr;
  assign M_WD        = w_sel.wd;
  assign M_WE        = w_sel.we;
  assign M_WE_LEN    = w_sel.we_len;
  assign M_WE_A      = w_sel.we_a;
  assign RD          = M_RD;
  assign BUSY_OUT[0] = r_gnt[0] ? M_BUSY : 1'b1;
  assign BUSY_OUT[1] = r_gnt[1] ? M_BUSY : 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arb
// Brief    : Directed-vector bench for sdram_arb (TIMEOUT_CYCLES = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arb;

  localparam logic [7:0]  C_A0 = 8'h05;
  localparam logic [7:0]  C_A1 = 8'h33;
  localparam logic [31:0] C_D0 = 32'hDEADBEEF;
  localparam logic [31:0] C_D1 = 32'h12345678;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  REQ;
  logic [1:0]  GNT;
  logic [7:0]  ADDR0, ADDR1;
  logic [31:0] WD0, WD1;
  logic        WE0, WE1, WE_LEN0, WE_LEN1, WE_A0, WE_A1;
  logic [31:0] RD;
  logic [1:0]  BUSY_OUT;
  logic [7:0]  M_ADDR;
  logic [31:0] M_WD;
  logic        M_WE, M_WE_LEN, M_WE_A;
  logic [31:0] M_RD;
  logic        M_BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       we0;
    logic       we1;
    logic       mb;
    logic [1:0] e_gnt;
    logic       e_we;
    logic       e_sel;
    logic [1:0] e_busy;
  } vec_t;

  vec_t tbl[$];

  sdram_arb #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(GNT),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WD0(WD0), .WD1(WD1),
    .WE0(WE0), .WE1(WE1), .WE_LEN0(WE_LEN0), .WE_LEN1(WE_LEN1),
    .WE_A0(WE_A0), .WE_A1(WE_A1), .RD(RD), .BUSY_OUT(BUSY_OUT),
    .M_ADDR(M_ADDR), .M_WD(M_WD), .M_WE(M_WE), .M_WE_LEN(M_WE_LEN),
    .M_WE_A(M_WE_A), .M_RD(M_RD), .M_BUSY(M_BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic we0,
                              input logic we1, input logic mb, input logic [1:0] e_gnt,
                              input logic e_we, input logic e_sel, input logic [1:0] e_busy);
    vec_t v;
    v.rst = rst; v.req = req; v.we0 = we0; v.we1 = we1; v.mb = mb;
    v.e_gnt = e_gnt; v.e_we = e_we; v.e_sel = e_sel; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the edge, check mid-cycle, advance past the next edge.
  task automatic step(input vec_t v, input string tag, input int idx);
    logic [31:0] rd_pat;
    rd_pat  = 32'hA5A50000 + 32'(idx);
    RESET   = v.rst;
    REQ     = v.req;
    WE0 = v.we0; WE_LEN0 = v.we0; WE_A0 = v.we0;
    WE1 = v.we1; WE_LEN1 = v.we1; WE_A1 = v.we1;
    M_BUSY  = v.mb;
    M_RD    = rd_pat;
    @(negedge CLK);
    chk({tag, ".gnt"},    idx, 32'(GNT),      32'(v.e_gnt));
    chk({tag, ".we"},     idx, 32'(M_WE),     32'(v.e_we));
    chk({tag, ".we_len"}, idx, 32'(M_WE_LEN), 32'(v.e_we));
    chk({tag, ".we_a"},   idx, 32'(M_WE_A),   32'(v.e_we));
    chk({tag, ".addr"},   idx, 32'(M_ADDR),   32'(v.e_sel ? C_A1 : C_A0));
    chk({tag, ".wd"},     idx, M_WD,          v.e_sel ? C_D1 : C_D0);
    chk({tag, ".busy"},   idx, 32'(BUSY_OUT), 32'(v.e_busy));
    chk({tag, ".rd"},     idx, RD,            rd_pat);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; REQ = 2'b00; M_BUSY = 1'b0;
    WE0 = 1'b0; WE_LEN0 = 1'b0; WE_A0 = 1'b0;
    WE1 = 1'b0; WE_LEN1 = 1'b0; WE_A1 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    ADDR0 = C_A0; ADDR1 = C_A1; WD0 = C_D0; WD1 = C_D1; M_RD = '0;
    RESET = 1'b1; REQ = 2'b01; M_BUSY = 1'b0;
    WE0 = 1'b1; WE_LEN0 = 1'b1; WE_A0 = 1'b1;
    WE1 = 1'b1; WE_LEN1 = 1'b1; WE_A1 = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset.gnt",  0, 32'(GNT),      32'd0);
    chk("reset.we",   0, 32'(M_WE),     32'd0);
    chk("reset.busy", 0, 32'(BUSY_OUT), 32'd3);
    @(posedge CLK);
    #1;

    // Single requester, same-cycle mux, foreign strobe dropped, release.
    tbl.push_back(mk(0, 2'b01, 0, 0, 0, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 2'b01, 1, 0, 0, 2'b01, 1, 0, 2'b10));
    tbl.push_back(mk(0, 2'b01, 0, 1, 0, 2'b01, 0, 0, 2'b10));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b01, 0, 0, 2'b10));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b11));
    // Both requesting from reset: 0 first, then 1, then 0 again.
    tbl.push_back(mk(1, 2'b11, 1, 0, 0, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 2'b11, 1, 0, 0, 2'b01, 1, 0, 2'b10));
    tbl.push_back(mk(0, 2'b10, 0, 0, 0, 2'b01, 0, 0, 2'b10));
    tbl.push_back(mk(0, 2'b10, 0, 0, 0, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 2'b10, 0, 0, 0, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 2'b10, 1, 1, 0, 2'b10, 1, 1, 2'b01));
    tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b10, 0, 1, 2'b01));
    tbl.push_back(mk(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 2'b11));
    tbl.push_back(mk(0, 2'b11, 0, 0, 0, 2'b01, 0, 0, 2'b10));
    tbl.push_back(mk(0, 2'b11, 0, 0, 1, 2'b01, 0, 0, 2'b11));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], "vec", i);

    // Release while the MAC is busy: DRAIN holds, pending REQ1 waits.
    step(mk(0, 2'b10, 0, 0, 1, 2'b01, 0, 0, 2'b11), "drain", 0);
    for (int i = 1; i <= 5; i++)
      step(mk(0, 2'b10, 0, 0, 1, 2'b00, 0, 0, 2'b11), "drain", i);
    step(mk(0, 2'b10, 0, 0, 0, 2'b00, 0, 0, 2'b11), "drain", 6);
    step(mk(0, 2'b10, 0, 0, 0, 2'b00, 0, 0, 2'b11), "drain", 7);
    step(mk(0, 2'b10, 0, 0, 0, 2'b10, 0, 1, 2'b01), "drain", 8);

    // Reset in the middle of a grant.
    step(mk(0, 2'b10, 0, 1, 0, 2'b10, 1, 1, 2'b01), "rstmid", 0);
    step(mk(1, 2'b10, 0, 1, 0, 2'b10, 0, 1, 2'b01), "rstmid", 1);
    step(mk(0, 2'b10, 0, 1, 0, 2'b00, 0, 0, 2'b11), "rstmid", 2);
    step(mk(0, 2'b10, 0, 1, 0, 2'b10, 1, 1, 2'b01), "rstmid", 3);

    do_reset();
`ifdef SDRAM_ARB_TIMEOUT_EN
    step(mk(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 2'b11), "wdt", 0);
    for (int i = 1; i <= 16; i++)
      step(mk(0, 2'b11, 0, 0, 0, 2'b01, 0, 0, 2'b10), "wdt", i);
    step(mk(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 2'b11), "wdt", 17);
    step(mk(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 2'b11), "wdt", 18);
    step(mk(0, 2'b11, 0, 0, 0, 2'b10, 0, 1, 2'b01), "wdt", 19);
    step(mk(0, 2'b01, 0, 0, 0, 2'b10, 0, 1, 2'b01), "wdt", 20);
    step(mk(0, 2'b01, 0, 0, 0, 2'b00, 0, 0, 2'b11), "wdt", 21);
    step(mk(0, 2'b01, 0, 0, 0, 2'b00, 0, 0, 2'b11), "wdt", 22);
    step(mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 2'b11), "wdt", 23);
    step(mk(0, 2'b01, 0, 0, 0, 2'b00, 0, 0, 2'b11), "wdt", 24);
    step(mk(0, 2'b01, 0, 0, 0, 2'b01, 0, 0, 2'b10), "wdt", 25);
`else
    step(mk(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 2'b11), "hold", 0);
    for (int i = 1; i <= 40; i++)
      step(mk(0, 2'b11, 0, 0, 0, 2'b01, 0, 0, 2'b10), "hold", i);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
